// File: rtl/alsu_cmd_issuer.sv
// Command issuer in front of the ALSU: buffers packed commands, drives the ALSU
// ports from registers (with optional repeat), and returns one tagged response per issue.
module alsu_cmd_issuer #(
  parameter int DEPTH    = 4,
  parameter int ALSU_LAT = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [18:0]      in_cmd,
  output logic [2:0]       opcode,
  output logic [2:0]       A,
  output logic [2:0]       B,
  output logic             cin,
  output logic             serial_in,
  output logic             direction,
  output logic             red_op_A,
  output logic             red_op_B,
  output logic             bypass_A,
  output logic             bypass_B,
  input  logic [5:0]       alsu_out,
  output logic             rsp_valid,
  output logic [5:0]       rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] err_count,
  output logic             fsm_state
);
  // Handshake: a command transfers at the rising edge where in_valid and in_ready are
  // both high; in_ready comes straight from a register. Responses have no backpressure.

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t             state, state_nx;
  logic [18:0]        mem [DEPTH];
  logic [PW:0]        wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic               empty, full_nx, push, pop, load, nop;
  logic [18:0]        head;
  logic [15:0]        port_q;
  logic [2:0]         rpt_cnt;
  logic [ALSU_LAT:0]  pipe_v, pipe_e;

  function automatic logic cmd_err(input logic [15:0] c);
    logic invalid_red, invalid_op;
    invalid_red = (c[12] | c[13]) & (c[1] | c[2]);
    invalid_op  = c[2] & c[1];
    return invalid_red | invalid_op;
  endfunction

  assign push      = in_valid & in_ready;
  assign empty     = (wr_ptr == rd_ptr);
  assign head      = mem[rd_ptr[PW-1:0]];
  assign wr_ptr_nx = wr_ptr + {{PW{1'b0}}, push};
  assign rd_ptr_nx = rd_ptr + {{PW{1'b0}}, pop};
  assign full_nx   = (wr_ptr_nx[PW] != rd_ptr_nx[PW]) &&
                     (wr_ptr_nx[PW-1:0] == rd_ptr_nx[PW-1:0]);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= in_cmd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nx;
      rd_ptr   <= rd_ptr_nx;
      in_ready <= !full_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    load     = 1'b0;
    nop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          load     = 1'b1;
          pop      = 1'b1;
          state_nx = ISSUE;
        end else begin
          nop = 1'b1;
        end
      end
      ISSUE: begin
        if (rpt_cnt != 3'd0) begin
          // repeat: ports hold, rpt_cnt steps down in the datapath
        end else if (!empty) begin
          load = 1'b1;
          pop  = 1'b1;
        end else begin
          nop      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Issue registers; pipe stage 0 travels with the command currently on the ports.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      port_q    <= '0;
      rpt_cnt   <= '0;
      pipe_v[0] <= 1'b0;
      pipe_e[0] <= 1'b0;
    end else if (load) begin
      port_q    <= head[15:0];
      rpt_cnt   <= head[18:16];
      pipe_v[0] <= 1'b1;
      pipe_e[0] <= cmd_err(head[15:0]);
    end else if (nop) begin
      port_q    <= '0;
      rpt_cnt   <= '0;
      pipe_v[0] <= 1'b0;
      pipe_e[0] <= 1'b0;
    end else begin
      rpt_cnt   <= rpt_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_v[ALSU_LAT:1] <= '0;
      pipe_e[ALSU_LAT:1] <= '0;
      rsp_valid          <= 1'b0;
      rsp_err            <= 1'b0;
      rsp_data           <= '0;
      busy               <= 1'b0;
      err_count          <= '0;
    end else begin
      pipe_v[ALSU_LAT:1] <= pipe_v[ALSU_LAT-1:0];
      pipe_e[ALSU_LAT:1] <= pipe_e[ALSU_LAT-1:0];
      rsp_valid          <= pipe_v[ALSU_LAT];
      rsp_err            <= pipe_v[ALSU_LAT] & pipe_e[ALSU_LAT];
      rsp_data           <= pipe_v[ALSU_LAT] ? alsu_out : 6'd0;
      busy               <= !empty || (state == ISSUE) || (|pipe_v);
      if (rsp_valid && rsp_err && (err_count != {CNT_W{1'b1}}))
        err_count <= err_count + 1'b1;
    end
  end

  assign opcode    = port_q[2:0];
  assign A         = port_q[5:3];
  assign B         = port_q[8:6];
  assign cin       = port_q[9];
  assign serial_in = port_q[10];
  assign direction = port_q[11];
  assign red_op_A  = port_q[12];
  assign red_op_B  = port_q[13];
  assign bypass_A  = port_q[14];
  assign bypass_B  = port_q[15];
  assign fsm_state = (state == ISSUE);

endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// Bench for alsu_cmd_issuer: a behavioural ALSU closes the loop, expected responses
// are queued at push time and compared in order against what the DUT emits.
module tb_alsu_cmd_issuer;
  localparam int DEPTH = 4;
  localparam int ALSU_LAT = 2;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [18:0] in_cmd = '0;
  logic [2:0] opcode, A, B;
  logic cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
  logic [5:0] alsu_out;
  logic rsp_valid, rsp_err, busy, fsm_state;
  logic [5:0] rsp_data;
  logic [CNT_W-1:0] err_count;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [6:0] exp_q[$];
  logic [6:0] obs_rsp[$];
  int obs_cyc[$];

  alsu_cmd_issuer #(.DEPTH(DEPTH), .ALSU_LAT(ALSU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .opcode(opcode), .A(A), .B(B), .cin(cin), .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .alsu_out(alsu_out), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .err_count(err_count), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Behavioural ALSU: inputs registered, output registered (two edges of latency).
  function automatic logic [5:0] alsu_f(input logic [15:0] c, input logic [5:0] prev);
    logic [2:0] op, a, b;
    op = c[2:0]; a = c[5:3]; b = c[8:6];
    if (((c[12] | c[13]) & (op[1] | op[2])) | (op[2] & op[1])) return 6'd0;
    if (c[14]) return {3'd0, a};
    if (c[15]) return {3'd0, b};
    case (op)
      3'd0: return c[12] ? {5'd0, |a} : c[13] ? {5'd0, |b} : {3'd0, a | b};
      3'd1: return c[12] ? {5'd0, ^a} : c[13] ? {5'd0, ^b} : {3'd0, a ^ b};
      3'd2: return {3'd0, a} + {3'd0, b} + {5'd0, c[9]};
      3'd3: return {3'd0, a} * {3'd0, b};
      3'd4: return c[11] ? {prev[4:0], c[10]} : {c[10], prev[5:1]};
      default: return c[11] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
    endcase
  endfunction

  logic [15:0] m_in;
  logic [5:0] m_out;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_in <= '0;
      m_out <= '0;
    end else begin
      m_in <= {bypass_B, bypass_A, red_op_B, red_op_A, direction, serial_in, cin, B, A, opcode};
      m_out <= alsu_f(m_in, m_out);
    end
  end
  assign alsu_out = m_out;

  function automatic logic [18:0] mk(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                     input logic c_in, input logic dir, input logic ra,
                                     input logic ba, input logic [2:0] rpt);
    return {rpt, 1'b0, ba, 1'b0, ra, dir, 1'b0, c_in, b, a, op};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rsp_valid === 1'b1) begin
      obs_cyc.push_back(cyc);
      obs_rsp.push_back({rsp_err, rsp_data});
    end
  endtask

  task automatic push_cmd(input logic [18:0] c, input int budget, output bit ok);
    int k = 0;
    in_valid = 1'b1;
    in_cmd = c;
    while (in_ready !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    ok = (in_ready === 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int k = 0;
    while (obs_rsp.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    #3;
    n_chk++;
    if ({in_ready, rsp_valid, rsp_err, rsp_data, busy, err_count, opcode, A, B, fsm_state} !== '0)
      $display("FAIL reset_outputs: got %b required all zero",
               {in_ready, rsp_valid, rsp_err, rsp_data, busy, err_count, opcode, A, B, fsm_state});
    else n_pass++;
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    n_chk++;
    if ({in_ready, busy, fsm_state, err_count} !== {1'b1, 1'b0, 1'b0, {CNT_W{1'b0}}})
      $display("FAIL reset_release: in_ready=%b busy=%b state=%b err_count=%0d required 1 0 0 0",
               in_ready, busy, fsm_state, err_count);
    else n_pass++;
  endtask

  task automatic test_single();
    int c0;
    bit ok;
    obs_cyc.delete(); obs_rsp.delete();
    c0 = cyc;
    exp_q.push_back({1'b0, 6'd8});
    push_cmd(mk(3'd2, 3'd3, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0), 4, ok);
    tick();
    n_chk++;
    if ({opcode, A, B, cin} !== {3'd2, 3'd3, 3'd4, 1'b1})
      $display("FAIL single_ports: cycle %0d got op=%0d A=%0d B=%0d cin=%b required 2 3 4 1",
               cyc - c0, opcode, A, B, cin);
    else n_pass++;
    wait_rsp(1, 10);
    n_chk++;
    if (obs_rsp.size() != 1 || obs_cyc[0] != c0 + 5)
      $display("FAIL single_latency: got %0d responses, first at cycle %0d, required 1 at cycle 5",
               obs_rsp.size(), (obs_cyc.size() > 0) ? obs_cyc[0] - c0 : -1);
    else n_pass++;
    while (obs_rsp.size() > 0 && exp_q.size() > 0) begin
      logic [6:0] o, e;
      o = obs_rsp.pop_front(); e = exp_q.pop_front();
      n_chk++;
      if (o !== e) $display("FAIL single_data: got err=%b data=%0d required err=%b data=%0d",
                            o[6], o[5:0], e[6], e[5:0]);
      else n_pass++;
    end
    tick();
    n_chk++;
    if (busy !== 1'b0 || err_count !== '0)
      $display("FAIL single_idle: cycle %0d busy=%b err_count=%0d required 0 0", cyc - c0, busy, err_count);
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    obs_cyc.delete(); obs_rsp.delete();
    exp_q.push_back({1'b0, 6'd5});
    exp_q.push_back({1'b0, 6'd10});
    exp_q.push_back({1'b0, 6'd20});
    exp_q.push_back({1'b0, 6'd40});
    push_cmd(mk(3'd0, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0), 4, ok);
    push_cmd(mk(3'd5, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2), 4, ok);
    wait_rsp(4, 20);
    n = obs_rsp.size();
    n_chk++;
    if (n != 4 || obs_cyc[3] - obs_cyc[0] != 3)
      $display("FAIL b2b_spacing: got %0d responses spanning %0d cycles, required 4 spanning 3",
               n, (n > 0) ? obs_cyc[n-1] - obs_cyc[0] : -1);
    else n_pass++;
    while (obs_rsp.size() > 0 && exp_q.size() > 0) begin
      logic [6:0] o, e;
      o = obs_rsp.pop_front(); e = exp_q.pop_front();
      n_chk++;
      if (o !== e) $display("FAIL b2b_data: got err=%b data=%0d required err=%b data=%0d",
                            o[6], o[5:0], e[6], e[5:0]);
      else n_pass++;
    end
    exp_q.delete();
  endtask

  task automatic test_errors();
    bit ok;
    logic [18:0] cmds [2];
    cmds[0] = mk(3'd6, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    cmds[1] = mk(3'd2, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 2; i++) begin
      obs_cyc.delete(); obs_rsp.delete();
      push_cmd(cmds[i], 4, ok);
      wait_rsp(1, 10);
      n_chk++;
      if (obs_rsp.size() != 1 || obs_rsp[0] !== {1'b1, 6'd0})
        $display("FAIL err_rsp%0d: got %0d responses, first %b, required one 1000000",
                 i, obs_rsp.size(), (obs_rsp.size() > 0) ? obs_rsp[0] : 7'bx);
      else n_pass++;
      tick();
      n_chk++;
      if (err_count !== CNT_W'(i + 1))
        $display("FAIL err_count%0d: got %0d required %0d", i, err_count, i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_full();
    int idx = 0, guard = 0, fall_cyc = -1, rise_cyc = -1, acc_at_fall = -1;
    obs_cyc.delete(); obs_rsp.delete();
    in_valid = 1'b1;
    while (idx < 6 && guard < 200) begin
      in_cmd = mk(3'd2, 3'(idx), 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7);
      if (in_ready !== 1'b1 && fall_cyc < 0) begin
        fall_cyc = cyc;
        acc_at_fall = idx;
      end
      if (in_ready === 1'b1 && fall_cyc >= 0 && rise_cyc < 0) rise_cyc = cyc;
      if (in_ready === 1'b1) begin
        for (int r = 0; r < 8; r++) exp_q.push_back({1'b0, 6'(idx + 1)});
        idx++;
      end
      tick();
      guard++;
    end
    in_valid = 1'b0;
    // one command has already moved into the issue registers when the FIFO fills
    n_chk++;
    if (acc_at_fall != DEPTH + 1)
      $display("FAIL full_accepted: in_ready fell after %0d accepts, required %0d", acc_at_fall, DEPTH + 1);
    else n_pass++;
    n_chk++;
    if (fall_cyc < 0 || rise_cyc - fall_cyc != 5)
      $display("FAIL full_low_time: in_ready low for %0d cycles, required 5", rise_cyc - fall_cyc);
    else n_pass++;
    wait_rsp(48, 300);
    for (int k = 0; k < 8; k++) tick();
    n_chk++;
    if (obs_rsp.size() != 48)
      $display("FAIL full_count: got %0d responses required 48", obs_rsp.size());
    else n_pass++;
    while (obs_rsp.size() > 0 && exp_q.size() > 0) begin
      logic [6:0] o, e;
      o = obs_rsp.pop_front(); e = exp_q.pop_front();
      n_chk++;
      if (o !== e) $display("FAIL full_data: got err=%b data=%0d required err=%b data=%0d",
                            o[6], o[5:0], e[6], e[5:0]);
      else n_pass++;
    end
    exp_q.delete();
  endtask

  task automatic test_mid_reset();
    bit ok;
    obs_cyc.delete(); obs_rsp.delete();
    for (int i = 0; i < 3; i++) push_cmd(mk(3'd2, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3), 4, ok);
    n_chk++;
    if (busy !== 1'b1 || fsm_state !== 1'b1 || err_count !== CNT_W'(2))
      $display("FAIL prereset_state: busy=%b state=%b err_count=%0d required 1 1 2", busy, fsm_state, err_count);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({in_ready, rsp_valid, rsp_err, rsp_data, busy, err_count, opcode, A, B, cin, fsm_state} !== '0)
      $display("FAIL midreset_outputs: got %b required all zero",
               {in_ready, rsp_valid, rsp_err, rsp_data, busy, err_count, opcode, A, B, cin, fsm_state});
    else n_pass++;
    tick(); tick();
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    n_chk++;
    if (obs_rsp.size() != 0 || err_count !== '0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL postreset: responses=%0d err_count=%0d in_ready=%b busy=%b required 0 0 1 0",
               obs_rsp.size(), err_count, in_ready, busy);
    else n_pass++;
  endtask

  task automatic test_saturate();
    bit ok;
    int n_cmd;
    n_cmd = (1 << CNT_W) + 3;
    obs_cyc.delete(); obs_rsp.delete();
    for (int i = 0; i < n_cmd; i++) begin
      exp_q.push_back({1'b1, 6'd0});
      push_cmd(mk(3'd7, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0), 8, ok);
    end
    wait_rsp(n_cmd, 100);
    tick(); tick();
    n_chk++;
    if (obs_rsp.size() != n_cmd)
      $display("FAIL sat_count: got %0d responses required %0d", obs_rsp.size(), n_cmd);
    else n_pass++;
    while (obs_rsp.size() > 0 && exp_q.size() > 0) begin
      logic [6:0] o, e;
      o = obs_rsp.pop_front(); e = exp_q.pop_front();
      n_chk++;
      if (o !== e) $display("FAIL sat_data: got err=%b data=%0d required err=%b data=%0d",
                            o[6], o[5:0], e[6], e[5:0]);
      else n_pass++;
    end
    n_chk++;
    if (err_count !== {CNT_W{1'b1}})
      $display("FAIL sat_err_count: got %0d required %0d", err_count, (1 << CNT_W) - 1);
    else n_pass++;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_errors();
    test_full();
    test_mid_reset();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
